// File: rtl/mac_sequencer_pkg.sv
// Shared constants and FSM state type for the MAC sequencer and its surroundings.
package mac_sequencer_pkg;

   localparam int unsigned NUM_INPUTS  = 784;
   localparam int unsigned NUM_NEURONS = 10;
   localparam int unsigned DATA_W      = 8;
   localparam int unsigned ADDR_W      = 10;
   localparam int unsigned LANES_W     = NUM_NEURONS * DATA_W;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLEAR  = 3'd1,
      S_STREAM = 3'd2,
      S_DRAIN  = 3'd3,
      S_DONE   = 3'd4
   } seq_state_t;

endpackage

// File: rtl/mac_sequencer_if.sv
// Control, memory-read and perceptron-feed signals of the MAC sequencer.
interface mac_sequencer_if;
   import mac_sequencer_pkg::*;

   logic                  start;
   logic                  pause;
   logic                  busy;
   logic                  done;
   logic [ADDR_W-1:0]     mem_addr;
   logic                  mem_re;
   logic [DATA_W-1:0]     pix_rdata;
   logic [LANES_W-1:0]    w_rdata;
   logic                  mac_clear;
   logic                  mac_en;
   logic [DATA_W-1:0]     data_in;
   logic [LANES_W-1:0]    weight;

   // Sequencer side
   modport master (
      input  start, pause, pix_rdata, w_rdata,
      output busy, done, mem_addr, mem_re, mac_clear, mac_en, data_in, weight
   );

   // Memories, perceptrons and control host side
   modport slave (
      output start, pause, pix_rdata, w_rdata,
      input  busy, done, mem_addr, mem_re, mac_clear, mac_en, data_in, weight
   );

endinterface

// File: rtl/mac_sequencer_index_counter.sv
// Read-address counter: clears to 0, increments up to LAST and saturates there.
module index_counter
   import mac_sequencer_pkg::*;
#(
   parameter int unsigned W    = ADDR_W,
   parameter int unsigned LAST = NUM_INPUTS - 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] idx_o,
   output logic         last_o
);

   logic [W-1:0] idx_q, idx_d;
   logic         last_q, last_d;

   // Last flag is precomputed so it is a plain register bit
   always_comb begin
      idx_d  = idx_q;
      last_d = last_q;
      if (clr_i) begin
         idx_d  = '0;
         last_d = (LAST == 0);
      end else if (inc_i && !last_q) begin
         idx_d  = idx_q + W'(1);
         last_d = (idx_d == W'(LAST));
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         idx_q  <= '0;
         last_q <= (LAST == 0);
      end else begin
         idx_q  <= idx_d;
         last_q <= last_d;
      end
   end

   assign idx_o  = idx_q;
   assign last_o = last_q;

endmodule

// File: rtl/mac_sequencer.sv
// Clears the perceptron bank, streams NUM_INPUTS pixel/weight reads into it,
// then pulses done once the final accumulate has landed.
module mac_sequencer
   import mac_sequencer_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   mac_sequencer_if.master bus
);

   seq_state_t        state_q, state_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              mem_re_q, mem_re_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              mac_clear_q, mac_clear_d;
   logic              mac_en_q;

   logic              cnt_clr;
   logic              cnt_inc;
   logic              cnt_last;
   logic [ADDR_W-1:0] cnt_idx;
   logic              last_issued;

   index_counter #(
      .W    (ADDR_W),
      .LAST (NUM_INPUTS - 1)
   ) u_index_counter (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (cnt_clr),
      .inc_i  (cnt_inc),
      .idx_o  (cnt_idx),
      .last_o (cnt_last)
   );

   // Counter saturates at the last index, so a read of that index is the final one
   assign last_issued = mem_re_q && cnt_last && (mem_addr_q == cnt_idx);

   // Outputs are registered from the next state so they line up with the state they describe
   always_comb begin
      state_d     = state_q;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      mac_clear_d = 1'b0;
      mem_re_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      cnt_clr     = 1'b0;
      cnt_inc     = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            cnt_clr = 1'b1;
            if (bus.start) state_d = S_CLEAR;
         end
         S_CLEAR, S_STREAM: begin
            if (last_issued) begin
               state_d = S_DRAIN;
            end else begin
               state_d = S_STREAM;
               if (!bus.pause) begin
                  mem_re_d   = 1'b1;
                  mem_addr_d = cnt_idx;
                  cnt_inc    = 1'b1;
               end
            end
         end
         S_DRAIN: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      busy_d      = (state_d != S_IDLE);
      done_d      = (state_d == S_DONE);
      mac_clear_d = (state_d == S_CLEAR);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         mem_re_q    <= 1'b0;
         mem_addr_q  <= '0;
         mac_clear_q <= 1'b0;
         mac_en_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         mem_re_q    <= mem_re_d;
         mem_addr_q  <= mem_addr_d;
         mac_clear_q <= mac_clear_d;
         mac_en_q    <= mem_re_q;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.mem_re    = mem_re_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mac_clear = mac_clear_q;
   assign bus.mac_en    = mac_en_q;
   assign bus.data_in   = bus.pix_rdata;
   assign bus.weight    = bus.w_rdata;

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: memory and perceptron-bank models around the DUT, stream-level expectations.
module tb_mac_sequencer;
   import mac_sequencer_pkg::*;

   localparam int N  = NUM_INPUTS;
   localparam int NN = NUM_NEURONS;

   logic clk = 1'b0;
   logic rst;

   mac_sequencer_if bus();

   mac_sequencer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic signed [DATA_W-1:0] pix_mem [N];
   logic signed [DATA_W-1:0] w_mem   [N][NN];
   logic [10:0]              acc     [NN];

   // Pixel and weight memories, one cycle read latency
   always @(posedge clk) begin
      if (bus.mem_re) begin
         bus.pix_rdata <= pix_mem[int'(bus.mem_addr)];
         for (int n = 0; n < NN; n++)
            bus.w_rdata[n*DATA_W +: DATA_W] <= w_mem[int'(bus.mem_addr)][n];
      end
   end

   // Perceptron bank: 11-bit accumulators of (pixel*weight)>>>5
   always @(posedge clk) begin
      for (int n = 0; n < NN; n++) begin
         if (bus.mac_clear)
            acc[n] <= '0;
         else if (bus.mac_en)
            acc[n] <= acc[n] + 11'((int'($signed(bus.data_in)) *
                                    int'($signed(bus.weight[n*DATA_W +: DATA_W]))) >>> 5);
      end
   end

   // Observation results of the last window
   int ob_clear_cnt, ob_clear_first, ob_en_cnt, ob_en_first, ob_en_last;
   int ob_busy_cnt, ob_overlap, ob_addr_err, ob_hold_err, ob_max_gap, ob_exp_done;
   int ob_done_q[$];

   function automatic int first_done();
      return (ob_done_q.size() > 0) ? ob_done_q[0] : -1;
   endfunction

   // Starts a run at the current negedge and records what the DUT does for max_cyc cycles.
   // Cycle c is the interval after edge c-1; start is accepted at edge 0.
   task automatic observe(input int max_cyc, input bit hold_start, input bit rand_pause,
                          input int pause_at, input int pause_len, input int pulse_at);
      int issued = 0, next_addr = 0, pause_left = 0, cur_gap = 0, c;
      bit paused_once = 0;
      logic [ADDR_W-1:0] prev_addr;
      ob_clear_cnt = 0; ob_clear_first = -1; ob_en_cnt = 0; ob_en_first = -1; ob_en_last = -1;
      ob_busy_cnt = 0; ob_overlap = 0; ob_addr_err = 0; ob_hold_err = 0; ob_max_gap = 0;
      ob_exp_done = -1;
      ob_done_q.delete();
      prev_addr = bus.mem_addr;
      bus.start = 1'b1;
      bus.pause = 1'b0;
      for (int t = 0; t < max_cyc; t++) begin
         @(posedge clk);
         // Stream model: every edge after the start edge issues one read unless paused
         if (t >= 1 && issued < N && !bus.pause) begin
            issued++;
            if (issued == N) ob_exp_done = t + 3;
         end
         @(negedge clk);
         c = t + 1;
         if (bus.mac_clear) begin
            if (ob_clear_cnt == 0) ob_clear_first = c;
            ob_clear_cnt++;
         end
         if (bus.mac_en) begin
            if (ob_en_cnt == 0) ob_en_first = c;
            else if (cur_gap > ob_max_gap) ob_max_gap = cur_gap;
            cur_gap = 0;
            ob_en_last = c;
            ob_en_cnt++;
         end else if (ob_en_cnt > 0) begin
            cur_gap++;
         end
         if (bus.busy) ob_busy_cnt++;
         if (bus.mac_clear && bus.mac_en) ob_overlap++;
         if (bus.done) ob_done_q.push_back(c);
         if (bus.mem_re) begin
            if (bus.mem_addr != ADDR_W'(next_addr)) ob_addr_err++;
            next_addr = (next_addr + 1) % N;
            prev_addr = bus.mem_addr;
         end else if (bus.mem_addr !== prev_addr) begin
            ob_hold_err++;
         end
         if (hold_start) bus.start = (ob_done_q.size() < 2);
         else            bus.start = (pulse_at > 0 && c == pulse_at);
         if (pause_left > 0) begin
            bus.pause = 1'b1;
            pause_left--;
         end else if (pause_at >= 0 && !paused_once && bus.mem_re &&
                      bus.mem_addr == ADDR_W'(pause_at)) begin
            bus.pause   = 1'b1;
            pause_left  = pause_len - 1;
            paused_once = 1'b1;
         end else begin
            bus.pause = rand_pause ? ($urandom_range(0, 7) == 0) : 1'b0;
         end
      end
      bus.start = 1'b0;
      bus.pause = 1'b0;
   endtask

   task automatic load_const(input int pix, input bit lane_ramp, input int wval);
      for (int i = 0; i < N; i++) begin
         pix_mem[i] = DATA_W'(pix);
         for (int n = 0; n < NN; n++) w_mem[i][n] = DATA_W'(lane_ramp ? n + 1 : wval);
      end
   endtask

   task automatic test_reset();
      int waited = 0, dones = 0;
      rst = 1'b0; bus.start = 1'b0; bus.pause = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.done, bus.mem_re, bus.mac_clear, bus.mac_en, bus.mem_addr} !== '0) begin
         errors++;
         $display("FAIL reset_init: outputs busy=%b done=%b re=%b clr=%b en=%b addr=%0d, required all 0",
                  bus.busy, bus.done, bus.mem_re, bus.mac_clear, bus.mac_en, bus.mem_addr);
      end
      rst = 1'b1;
      @(negedge clk);
      load_const(1, 1'b0, 1);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      while (!(bus.mem_re && bus.mem_addr == ADDR_W'(300)) && waited < 1000) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (waited >= 1000) begin
         errors++;
         $display("FAIL reset_reach_idx300: address 300 not issued within %0d cycles", waited);
      end
      rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.done, bus.mem_re, bus.mac_clear, bus.mac_en, bus.mem_addr} !== '0) begin
         errors++;
         $display("FAIL reset_midrun: outputs busy=%b done=%b re=%b clr=%b en=%b addr=%0d, required all 0",
                  bus.busy, bus.done, bus.mem_re, bus.mac_clear, bus.mac_en, bus.mem_addr);
      end
      rst = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (bus.done || bus.busy || bus.mem_re) dones++;
      end
      checks++;
      if (dones != 0) begin
         errors++;
         $display("FAIL reset_no_done: %0d active cycles after abandoned run, required 0", dones);
      end
   endtask

   task automatic test_basic();
      load_const(32, 1'b0, 8);
      observe(800, 1'b0, 1'b0, -1, 0, 0);
      checks++;
      if (ob_clear_cnt != 1 || ob_clear_first != 1) begin
         errors++;
         $display("FAIL basic_clear: count=%0d first=%0d, required count 1 at cycle 1",
                  ob_clear_cnt, ob_clear_first);
      end
      checks++;
      if (ob_en_cnt != N || ob_en_first != 3 || ob_en_last != N + 2) begin
         errors++;
         $display("FAIL basic_en: count=%0d cycles %0d..%0d, required %0d cycles 3..%0d",
                  ob_en_cnt, ob_en_first, ob_en_last, N, N + 2);
      end
      checks++;
      if (ob_done_q.size() != 1 || first_done() != N + 3) begin
         errors++;
         $display("FAIL basic_done: %0d pulses first at %0d, required 1 pulse at %0d",
                  ob_done_q.size(), first_done(), N + 3);
      end
      checks++;
      if (ob_busy_cnt != N + 3) begin
         errors++;
         $display("FAIL basic_busy: %0d busy cycles, required %0d", ob_busy_cnt, N + 3);
      end
      checks++;
      if (ob_overlap != 0 || ob_addr_err != 0 || ob_hold_err != 0) begin
         errors++;
         $display("FAIL basic_stream: overlap=%0d addr_err=%0d hold_err=%0d, required 0 0 0",
                  ob_overlap, ob_addr_err, ob_hold_err);
      end
      for (int n = 0; n < NN; n++) begin
         checks++;
         if (acc[n] !== 11'(N * ((32 * 8) >> 5))) begin
            errors++;
            $display("FAIL basic_sum[%0d]: got %0d, required %0d", n, acc[n], 11'(N * ((32 * 8) >> 5)));
         end
      end
   endtask

   task automatic test_pause();
      load_const(32, 1'b1, 0);
      observe(820, 1'b0, 1'b0, 100, 5, 0);
      checks++;
      if (first_done() != N + 3 + 5 || ob_done_q.size() != 1) begin
         errors++;
         $display("FAIL pause_done: %0d pulses first at %0d, required 1 at %0d",
                  ob_done_q.size(), first_done(), N + 8);
      end
      checks++;
      if (ob_max_gap != 5 || ob_en_cnt != N) begin
         errors++;
         $display("FAIL pause_en_gap: gap=%0d count=%0d, required gap 5 count %0d",
                  ob_max_gap, ob_en_cnt, N);
      end
      checks++;
      if (ob_hold_err != 0 || ob_addr_err != 0) begin
         errors++;
         $display("FAIL pause_addr: hold_err=%0d addr_err=%0d, required 0 0", ob_hold_err, ob_addr_err);
      end
      for (int n = 0; n < NN; n++) begin
         checks++;
         if (acc[n] !== 11'(N * (n + 1))) begin
            errors++;
            $display("FAIL lane_sum[%0d]: got %0d, required %0d", n, acc[n], 11'(N * (n + 1)));
         end
      end
   endtask

   task automatic test_start_busy();
      load_const(32, 1'b0, 8);
      observe(800, 1'b0, 1'b0, -1, 0, 50);
      checks++;
      if (ob_done_q.size() != 1 || first_done() != N + 3 || ob_clear_cnt != 1) begin
         errors++;
         $display("FAIL start_busy: %0d done at %0d clears=%0d, required 1 done at %0d, 1 clear",
                  ob_done_q.size(), first_done(), ob_clear_cnt, N + 3);
      end
   endtask

   task automatic test_random();
      int exp_sum;
      for (int i = 0; i < N; i++) begin
         pix_mem[i] = DATA_W'($urandom);
         for (int n = 0; n < NN; n++) w_mem[i][n] = DATA_W'($urandom);
      end
      observe(1100, 1'b0, 1'b1, -1, 0, 0);
      checks++;
      if (ob_done_q.size() != 1 || first_done() != ob_exp_done) begin
         errors++;
         $display("FAIL random_done: %0d pulses first at %0d, required 1 at %0d",
                  ob_done_q.size(), first_done(), ob_exp_done);
      end
      checks++;
      if (ob_en_cnt != N || ob_addr_err != 0 || ob_hold_err != 0 || ob_overlap != 0) begin
         errors++;
         $display("FAIL random_stream: en=%0d addr_err=%0d hold_err=%0d overlap=%0d, required %0d 0 0 0",
                  ob_en_cnt, ob_addr_err, ob_hold_err, ob_overlap, N);
      end
      for (int n = 0; n < NN; n++) begin
         exp_sum = 0;
         for (int i = 0; i < N; i++) exp_sum += (int'(pix_mem[i]) * int'(w_mem[i][n])) >>> 5;
         checks++;
         if (acc[n] !== 11'(exp_sum)) begin
            errors++;
            $display("FAIL random_sum[%0d]: got %0d, required %0d", n, acc[n], 11'(exp_sum));
         end
      end
   endtask

   task automatic test_back_to_back();
      load_const(32, 1'b0, 8);
      observe(1600, 1'b1, 1'b0, -1, 0, 0);
      checks++;
      if (ob_done_q.size() != 2) begin
         errors++;
         $display("FAIL b2b_count: %0d done pulses, required 2", ob_done_q.size());
      end else begin
         checks++;
         if (ob_done_q[0] != N + 3 || ob_done_q[1] - ob_done_q[0] != N + 4) begin
            errors++;
            $display("FAIL b2b_spacing: done at %0d and %0d, required %0d and %0d",
                     ob_done_q[0], ob_done_q[1], N + 3, 2 * N + 7);
         end
      end
      checks++;
      if (ob_en_cnt != 2 * N || ob_clear_cnt != 2 || ob_overlap != 0) begin
         errors++;
         $display("FAIL b2b_en: en=%0d clears=%0d overlap=%0d, required %0d 2 0",
                  ob_en_cnt, ob_clear_cnt, ob_overlap, 2 * N);
      end
   endtask

   initial begin
      bus.start = 1'b0;
      bus.pause = 1'b0;
      test_reset();
      test_basic();
      test_pause();
      test_start_busy();
      test_random();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
